// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types for the data-memory arbiter slice.
//   arb_state_t : two-phase access sequencer state (IDLE, ACCESS)
//   arb_owner_t : which port issued the command now in flight
//   mem_cmd_t   : latched memory command (write enable, address, write data)
// The command field widths are the widest address/data the arbiter can carry.
// Top-level ADDR_W/DATA_W are cast into and out of these fields, so they must
// not exceed CMD_ADDR_W/CMD_DATA_W.
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

   localparam int CMD_ADDR_W = 32;
   localparam int CMD_DATA_W = 32;

   // Wide enough for the whole legal STARVE_MAX range of 1..15.
   localparam int STARVE_W = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } arb_state_t;

   typedef enum logic {
      OWN_A = 1'b0,
      OWN_B = 1'b1
   } arb_owner_t;

   typedef struct packed {
      logic                  we;
      logic [CMD_ADDR_W-1:0] addr;
      logic [CMD_DATA_W-1:0] wdata;
   } mem_cmd_t;

endpackage

// File: rtl/arb_prio_starve.sv
// ---------------------------------------------------------------------------
// arb_prio_starve
// Winner selection between the CPU port (A) and the secondary master (B).
// A has priority. A starvation counter caps how many A grants in a row B
// can lose while it is waiting.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_en             arbitration window (sequencer idle and not in reset)
//   i_a_req, i_b_req requests from the two ports
//   o_gnt_a, o_gnt_b one-hot grant, only while i_en is high
// ---------------------------------------------------------------------------
module arb_prio_starve
   import dmem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_a_req,
   input  logic i_b_req,
   output logic o_gnt_a,
   output logic o_gnt_b
);

   localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_MAX);

   logic [STARVE_W-1:0] r_starve_cnt;
   logic                w_limit;
   logic                w_pick_b;

   // B wins when A is absent, or when A has already won LIMIT times in a row
   // while B was waiting.
   assign w_limit  = (r_starve_cnt == LIMIT);
   assign w_pick_b = i_b_req & (~i_a_req | w_limit);
   assign o_gnt_b  = i_en & w_pick_b;
   assign o_gnt_a  = i_en & i_a_req & ~w_pick_b;

   // The counter only moves in the arbitration window. A B grant, or B not
   // asking at all, clears it. Each A grant that B had to watch bumps it,
   // saturating at the limit so B is picked on the next window.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_starve_cnt <= '0;
      end else if (i_en) begin
         if (o_gnt_b || !i_b_req) begin
            r_starve_cnt <= '0;
         end else if (o_gnt_a && !w_limit) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the CPU load/store path (A)
// and a secondary master (B). One access at a time: a grant in IDLE latches
// the command, the memory op is driven in ACCESS, and read data comes back
// with a one-cycle registered valid pulse on the owning port.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_a_* / o_a_*                 port A: req, we, addr, wdata / gnt, rvalid, rdata
//   i_b_* / o_b_*                 port B: same as port A
//   o_mem_read, o_mem_write       memory command strobes
//   o_mem_addr, o_mem_wdata       memory address and write data
//   i_mem_rdata                   combinational read data from the memory
// ---------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_a_req,
   input  logic              i_a_we,
   input  logic [ADDR_W-1:0] i_a_addr,
   input  logic [DATA_W-1:0] i_a_wdata,
   output logic              o_a_gnt,
   output logic              o_a_rvalid,
   output logic [DATA_W-1:0] o_a_rdata,
   input  logic              i_b_req,
   input  logic              i_b_we,
   input  logic [ADDR_W-1:0] i_b_addr,
   input  logic [DATA_W-1:0] i_b_wdata,
   output logic              o_b_gnt,
   output logic              o_b_rvalid,
   output logic [DATA_W-1:0] o_b_rdata,
   output logic              o_mem_read,
   output logic              o_mem_write,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   arb_state_t        r_state;
   arb_owner_t        r_owner;
   mem_cmd_t          r_cmd;
   logic              r_a_rvalid;
   logic              r_b_rvalid;
   logic [DATA_W-1:0] r_a_rdata;
   logic [DATA_W-1:0] r_b_rdata;

   logic              w_arb_en;
   logic              w_access;
   logic              w_gnt_a;
   logic              w_gnt_b;

   // Grants are only possible while idle, and reset kills them in the same
   // cycle so nothing is accepted that the reset would then throw away.
   assign w_arb_en = (r_state == IDLE) && !i_rst;
   assign w_access = (r_state == ACCESS);

   arb_prio_starve #(
      .STARVE_MAX (STARVE_MAX)
   ) u_prio (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (w_arb_en),
      .i_a_req (i_a_req),
      .i_b_req (i_b_req),
      .o_gnt_a (w_gnt_a),
      .o_gnt_b (w_gnt_b)
   );

   assign o_a_gnt = w_gnt_a;
   assign o_b_gnt = w_gnt_b;

   // The memory command comes straight from the command register during
   // ACCESS and is not gated by reset: a write issued in the cycle reset
   // arrives still lands in memory at that edge.
   assign o_mem_read  = w_access & ~r_cmd.we;
   assign o_mem_write = w_access & r_cmd.we;
   assign o_mem_addr  = w_access ? ADDR_W'(r_cmd.addr)  : '0;
   assign o_mem_wdata = w_access ? DATA_W'(r_cmd.wdata) : '0;

   // Read valid is a registered pulse, but a reset arriving in the pulse
   // cycle must suppress it immediately.
   assign o_a_rvalid = r_a_rvalid & ~i_rst;
   assign o_b_rvalid = r_b_rvalid & ~i_rst;
   assign o_a_rdata  = r_a_rdata;
   assign o_b_rdata  = r_b_rdata;

   // Sequencer: IDLE latches the winning port's command and owner, ACCESS
   // always returns to IDLE. Read data is captured at the end of ACCESS into
   // the owner's data register, and the valid flag is raised for the
   // following cycle only. Data registers hold between reads.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_owner    <= OWN_A;
         r_cmd      <= '0;
         r_a_rvalid <= 1'b0;
         r_b_rvalid <= 1'b0;
         r_a_rdata  <= '0;
         r_b_rdata  <= '0;
      end else begin
         r_a_rvalid <= 1'b0;
         r_b_rvalid <= 1'b0;
         if (r_state == IDLE) begin
            if (w_gnt_a) begin
               r_cmd   <= '{we: i_a_we, addr: CMD_ADDR_W'(i_a_addr), wdata: CMD_DATA_W'(i_a_wdata)};
               r_owner <= OWN_A;
               r_state <= ACCESS;
            end else if (w_gnt_b) begin
               r_cmd   <= '{we: i_b_we, addr: CMD_ADDR_W'(i_b_addr), wdata: CMD_DATA_W'(i_b_wdata)};
               r_owner <= OWN_B;
               r_state <= ACCESS;
            end
         end else begin
            r_state <= IDLE;
            if (!r_cmd.we) begin
               if (r_owner == OWN_B) begin
                  r_b_rdata  <= i_mem_rdata;
                  r_b_rvalid <= 1'b1;
               end else begin
                  r_a_rdata  <= i_mem_rdata;
                  r_a_rvalid <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a small behavioural word memory.
// Inputs change just after the falling edge; outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

   logic        clk;
   logic        rst;
   logic        aReq, aWe, bReq, bWe;
   logic [31:0] aAddr, aWdata, bAddr, bWdata;
   logic        aGnt, aRvalid, bGnt, bRvalid;
   logic [31:0] aRdata, bRdata;
   logic        memRead, memWrite;
   logic [31:0] memAddr, memWdata, memRdata;

   logic        preWe;
   logic [3:0]  preIdx;
   logic [31:0] preData;
   logic [31:0] mem [0:15];
   logic        unusedAddrBits;

   int nCompared;
   int nMismatched;

   dmem_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .STARVE_MAX (4)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_a_req     (aReq),
      .i_a_we      (aWe),
      .i_a_addr    (aAddr),
      .i_a_wdata   (aWdata),
      .o_a_gnt     (aGnt),
      .o_a_rvalid  (aRvalid),
      .o_a_rdata   (aRdata),
      .i_b_req     (bReq),
      .i_b_we      (bWe),
      .i_b_addr    (bAddr),
      .i_b_wdata   (bWdata),
      .o_b_gnt     (bGnt),
      .o_b_rvalid  (bRvalid),
      .o_b_rdata   (bRdata),
      .o_mem_read  (memRead),
      .o_mem_write (memWrite),
      .o_mem_addr  (memAddr),
      .o_mem_wdata (memWdata),
      .i_mem_rdata (memRdata)
   );

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   // Word-addressed memory: combinational read, write on the rising edge.
   // A preload port lets the bench seed contents without using the arbiter.
   assign memRdata       = mem[memAddr[5:2]];
   assign unusedAddrBits = ^{memAddr[31:6], memAddr[1:0]};

   always @(posedge clk) begin
      if (preWe) mem[preIdx] <= preData;
      else if (memWrite) mem[memAddr[5:2]] <= memWdata;
   end

   // Drive one cycle's worth of inputs after the falling edge, then settle.
   task automatic applyStimulus(input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                                input logic br, input logic bw, input logic [31:0] ba, input logic [31:0] bd,
                                input logic r);
      @(negedge clk);
      rst    = r;
      aReq   = ar;
      aWe    = aw;
      aAddr  = aa;
      aWdata = ad;
      bReq   = br;
      bWe    = bw;
      bAddr  = ba;
      bWdata = bd;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      assert (observed === expected)
      else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic preload(input logic [3:0] idx, input logic [31:0] data);
      @(negedge clk);
      preWe   = 1'b1;
      preIdx  = idx;
      preData = data;
      @(negedge clk);
      preWe   = 1'b0;
   endtask

   logic [9:0] expB;
   int         grantIdx;

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      clk = 1'b0; rst = 1'b1; preWe = 1'b0; preIdx = '0; preData = '0;
      aReq = 1'b0; aWe = 1'b0; aAddr = '0; aWdata = '0;
      bReq = 1'b0; bWe = 1'b0; bAddr = '0; bWdata = '0;

      // Reset: a request during reset must not be granted.
      applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      checkOutput("rstGntA", aGnt, 32'd0);
      checkOutput("rstGntB", bGnt, 32'd0);
      preload(4'd0, 32'd10);
      preload(4'd1, 32'd20);
      preload(4'd2, 32'd0);
      preload(4'd3, 32'd0);

      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("rstARvalid", aRvalid, 32'd0);
      checkOutput("rstBRvalid", bRvalid, 32'd0);
      checkOutput("rstARdata", aRdata, 32'd0);
      checkOutput("rstBRdata", bRdata, 32'd0);
      checkOutput("rstMemRead", memRead, 32'd0);
      checkOutput("rstMemWrite", memWrite, 32'd0);
      checkOutput("rstMemAddr", memAddr, 32'd0);
      checkOutput("rstMemWdata", memWdata, 32'd0);

      // A reads addr 4 (mem[1] = 20); request held through ACCESS.
      applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("rdGntA", aGnt, 32'd1);
      checkOutput("rdGntB", bGnt, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("rdAccessNoGnt", aGnt, 32'd0);
      checkOutput("rdMemRead", memRead, 32'd1);
      checkOutput("rdMemWrite", memWrite, 32'd0);
      checkOutput("rdMemAddr", memAddr, 32'd4);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("rdARvalid", aRvalid, 32'd1);
      checkOutput("rdARdata", aRdata, 32'd20);
      checkOutput("rdBRvalid", bRvalid, 32'd0);

      // B writes 0x55 to addr 8, then A reads it back.
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h8, 32'h55, 1'b0);
      checkOutput("wrARvalidPulse", aRvalid, 32'd0);
      checkOutput("wrARdataHold", aRdata, 32'd20);
      checkOutput("wrGntB", bGnt, 32'd1);
      checkOutput("wrGntA", aGnt, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("wrMemWrite", memWrite, 32'd1);
      checkOutput("wrMemRead", memRead, 32'd0);
      checkOutput("wrMemAddr", memAddr, 32'd8);
      checkOutput("wrMemWdata", memWdata, 32'h55);
      applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("wrNoBRvalid", bRvalid, 32'd0);
      checkOutput("rbGntA", aGnt, 32'd1);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("rbMemAddr", memAddr, 32'd8);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("rbARvalid", aRvalid, 32'd1);
      checkOutput("rbARdata", aRdata, 32'h55);
      checkOutput("rbMem2", mem[2], 32'h55);

      // Simultaneous reads: A addr 0 wins, B addr 4 follows.
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
      checkOutput("simGntA", aGnt, 32'd1);
      checkOutput("simGntB", bGnt, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
      checkOutput("simAccessNoGntB", bGnt, 32'd0);
      checkOutput("simMemAddrA", memAddr, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
      checkOutput("simARvalid", aRvalid, 32'd1);
      checkOutput("simARdata", aRdata, 32'd10);
      checkOutput("simGntBLate", bGnt, 32'd1);
      checkOutput("simBRvalidEarly", bRvalid, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("simMemAddrB", memAddr, 32'd4);
      checkOutput("simMemReadB", memRead, 32'd1);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("simBRvalid", bRvalid, 32'd1);
      checkOutput("simBRdata", bRdata, 32'd20);
      checkOutput("simARvalidOff", aRvalid, 32'd0);

      // Starvation: both requests held; expected grants A,A,A,A,B,A,A,A,A,B.
      expB     = 10'b1000010000;
      grantIdx = 0;
      for (int c = 0; c < 20; c++) begin
         applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
         if (c % 2 == 0) begin
            if (c > 0) begin
               checkOutput("starveARvalid", aRvalid, {31'd0, ~expB[grantIdx-1]});
               checkOutput("starveBRvalid", bRvalid, {31'd0, expB[grantIdx-1]});
            end
            checkOutput("starveGntA", aGnt, {31'd0, ~expB[grantIdx]});
            checkOutput("starveGntB", bGnt, {31'd0, expB[grantIdx]});
            grantIdx++;
         end else begin
            checkOutput("starveAccessNoGnt", {30'd0, aGnt, bGnt}, 32'd0);
         end
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("starveLastBRvalid", bRvalid, 32'd1);
      checkOutput("starveLastBRdata", bRdata, 32'd20);

      // Reset during ACCESS of an A read: no rvalid, outputs back to reset values.
      applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("rrGntA", aGnt, 32'd1);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      checkOutput("rrMemReadInRst", memRead, 32'd1);
      checkOutput("rrMemAddrInRst", memAddr, 32'd4);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("rrNoARvalid", aRvalid, 32'd0);
      checkOutput("rrARdataCleared", aRdata, 32'd0);
      checkOutput("rrBRdataCleared", bRdata, 32'd0);
      checkOutput("rrMemReadOff", memRead, 32'd0);
      checkOutput("rrMemAddrOff", memAddr, 32'd0);

      // Reset during ACCESS of an A write of 7 to addr 0: the write still lands.
      applyStimulus(1'b1, 1'b1, 32'h0, 32'h7, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("rwGntA", aGnt, 32'd1);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      checkOutput("rwMemWriteInRst", memWrite, 32'd1);
      checkOutput("rwMemWdataInRst", memWdata, 32'd7);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("rwMemWriteOff", memWrite, 32'd0);
      checkOutput("rwMemWdataOff", memWdata, 32'd0);
      checkOutput("rwNoARvalid", aRvalid, 32'd0);
      checkOutput("rwMem0", mem[0], 32'd7);

      // Reset in the cycle the read valid would be high.
      applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("rvGntA", aGnt, 32'd1);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("rvMemRead", memRead, 32'd1);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      checkOutput("rvARvalidInRst", aRvalid, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("rvARvalidAfter", aRvalid, 32'd0);
      checkOutput("rvARdataCleared", aRdata, 32'd0);

      // Back-to-back A writes 1,2,3 to addrs 0,4,8 with request held.
      applyStimulus(1'b1, 1'b1, 32'h0, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("bbGnt1", aGnt, 32'd1);
      applyStimulus(1'b1, 1'b1, 32'h4, 32'h2, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("bbAccess1NoGnt", aGnt, 32'd0);
      checkOutput("bbMemWrite1", memWrite, 32'd1);
      checkOutput("bbMemAddr1", memAddr, 32'd0);
      checkOutput("bbMemWdata1", memWdata, 32'd1);
      applyStimulus(1'b1, 1'b1, 32'h4, 32'h2, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("bbIdle1NoWrite", memWrite, 32'd0);
      checkOutput("bbGnt2", aGnt, 32'd1);
      checkOutput("bbNoARvalid", aRvalid, 32'd0);
      applyStimulus(1'b1, 1'b1, 32'h8, 32'h3, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("bbMemWrite2", memWrite, 32'd1);
      checkOutput("bbMemAddr2", memAddr, 32'd4);
      checkOutput("bbMemWdata2", memWdata, 32'd2);
      applyStimulus(1'b1, 1'b1, 32'h8, 32'h3, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("bbGnt3", aGnt, 32'd1);
      checkOutput("bbIdle2NoWrite", memWrite, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("bbMemWrite3", memWrite, 32'd1);
      checkOutput("bbMemAddr3", memAddr, 32'd8);
      checkOutput("bbMemWdata3", memWdata, 32'd3);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("bbIdleEndNoWrite", memWrite, 32'd0);
      checkOutput("bbIdleEndNoGnt", aGnt, 32'd0);
      checkOutput("bbMem0", mem[0], 32'd1);
      checkOutput("bbMem1", mem[1], 32'd2);
      checkOutput("bbMem2", mem[2], 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
